// File: rtl/test_seq_ctrl.sv
// test_seq_ctrl: sequencer for the LFSR test-pattern path.
//
// Every rising edge of the test clock produces one serial bit. A run is a
// preamble (1010...), followed by burst_cnt PRBS bursts separated by zero gaps.
// The LFSR clock enable is gated so that the LFSR advances only on the bits it
// supplies. The output feeds the CDR under test.
//
// Optional feature macro: TEST_SEQ_ERR_INJ_EN
//   When defined, bit err_pos of every burst is sent inverted. The LFSR still
//   advances normally on that bit.
//   When undefined, err_pos_i is ignored.
//
// Ports:
//   clk_i, rst_n_i   system clock; synchronous active-low reset
//   test_clk_i       bit-rate clock, synchronous to clk_i; one bit per rising edge
//   start_i          start request, accepted only in IDLE
//   abort_i          return to IDLE immediately; done_o is not pulsed
//   preamble_len_i   preamble length in bits (latched at start)
//   burst_len_i      PRBS bits per burst (latched at start)
//   gap_len_i        zero bits between bursts (latched at start)
//   burst_cnt_i      bursts per run; 0 = run until aborted (latched at start)
//   err_pos_i        burst bit index to invert (latched at start)
//   prbs_bit_i       current LFSR output bit
//   prbs_en_o        LFSR clock enable, one pulse per PRBS bit
//   prbs_init_o      LFSR clear request, pulsed in the cycle a start is accepted
//   test_data_o      serial test bit
//   busy_o           high while a run is in progress
//   done_o           one-cycle pulse when a run completes normally
//   burst_idx_o      0-based index of the current burst
//
// state    | meaning
// S_IDLE   | waiting for start; test_data_o is 0
// S_PRE    | sending the alternating preamble
// S_BURST  | sending PRBS bits; LFSR enabled on each tick
// S_GAP    | sending zero bits between bursts
// S_DONE   | one-cycle completion pulse
module test_seq_ctrl #(
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             test_clk_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] preamble_len_i,
  input  logic [LEN_W-1:0] burst_len_i,
  input  logic [CNT_W-1:0] gap_len_i,
  input  logic [CNT_W-1:0] burst_cnt_i,
  input  logic [LEN_W-1:0] err_pos_i,
  input  logic             prbs_bit_i,
  output logic             prbs_en_o,
  output logic             prbs_init_o,
  output logic             test_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] burst_idx_o
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_BURST, S_GAP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             tclk_q, tick_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             data_q, data_d;
  logic             pre_bit_q, pre_bit_d;
  logic [CNT_W-1:0] pre_len_q, pre_len_d;
  logic [LEN_W-1:0] burst_len_q, burst_len_d;
  logic [CNT_W-1:0] gap_len_q, gap_len_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             accept, last_burst, inj;

`ifdef TEST_SEQ_ERR_INJ_EN
  logic [LEN_W-1:0] err_pos_q, err_pos_d;

  // cnt_q counts down, so the current bit index is burst_len-1-cnt.
  // The sums use one extra bit so they cannot overflow.
  assign inj = (state_q == S_BURST) && (err_pos_q < burst_len_q) &&
               (({1'b0, err_pos_q} + {1'b0, cnt_q}) == ({1'b0, burst_len_q} - 1'b1));
`else
  logic err_pos_unused;
  assign err_pos_unused = ^err_pos_i;
  assign inj = 1'b0;
`endif

  assign accept     = (state_q == S_IDLE) && start_i && !abort_i;
  assign last_burst = (burst_cnt_q != '0) && (idx_q == burst_cnt_q - CNT_W'(1));

  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign test_data_o = data_q;
  assign burst_idx_o = idx_q;
  // The LFSR advances on the same edge that captures its bit into data_q.
  assign prbs_en_o   = rst_n_i && tick_q && !abort_i && (state_q == S_BURST);
  assign prbs_init_o = rst_n_i && accept;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      tclk_q      <= 1'b0;
      tick_q      <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      data_q      <= 1'b0;
      pre_bit_q   <= 1'b0;
      pre_len_q   <= '0;
      burst_len_q <= '0;
      gap_len_q   <= '0;
      burst_cnt_q <= '0;
`ifdef TEST_SEQ_ERR_INJ_EN
      err_pos_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tclk_q      <= test_clk_i;
      tick_q      <= test_clk_i && !tclk_q;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      pre_bit_q   <= pre_bit_d;
      pre_len_q   <= pre_len_d;
      burst_len_q <= burst_len_d;
      gap_len_q   <= gap_len_d;
      burst_cnt_q <= burst_cnt_d;
`ifdef TEST_SEQ_ERR_INJ_EN
      err_pos_q   <= err_pos_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    data_d      = data_q;
    pre_bit_d   = pre_bit_q;
    pre_len_d   = pre_len_q;
    burst_len_d = burst_len_q;
    gap_len_d   = gap_len_q;
    burst_cnt_d = burst_cnt_q;
`ifdef TEST_SEQ_ERR_INJ_EN
    err_pos_d   = err_pos_q;
`endif

    if (abort_i) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      idx_d     = '0;
      data_d    = 1'b0;
      pre_bit_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          data_d = 1'b0;
          if (start_i) begin
            pre_len_d   = preamble_len_i;
            burst_len_d = burst_len_i;
            gap_len_d   = gap_len_i;
            burst_cnt_d = burst_cnt_i;
`ifdef TEST_SEQ_ERR_INJ_EN
            err_pos_d   = err_pos_i;
`endif
            idx_d     = '0;
            pre_bit_d = 1'b1;
            if (burst_len_i == '0) begin
              // Nothing to send: complete without emitting any bits.
              state_d = S_DONE;
              cnt_d   = '0;
            end else if (preamble_len_i == '0) begin
              state_d = S_BURST;
              cnt_d   = burst_len_i - LEN_W'(1);
            end else begin
              state_d = S_PRE;
              cnt_d   = LEN_W'(preamble_len_i) - LEN_W'(1);
            end
          end
        end
        S_PRE: begin
          if (tick_q) begin
            data_d    = pre_bit_q;
            pre_bit_d = !pre_bit_q;
            if (cnt_q == '0) begin
              state_d = S_BURST;
              cnt_d   = burst_len_q - LEN_W'(1);
            end else begin
              cnt_d = cnt_q - LEN_W'(1);
            end
          end
        end
        S_BURST: begin
          if (tick_q) begin
            data_d = prbs_bit_i ^ inj;
            if (cnt_q == '0) begin
              if (last_burst) begin
                state_d = S_DONE;
              end else if (gap_len_q == '0) begin
                // Back-to-back bursts; idx wraps freely in continuous mode.
                idx_d = idx_q + CNT_W'(1);
                cnt_d = burst_len_q - LEN_W'(1);
              end else begin
                state_d = S_GAP;
                cnt_d   = LEN_W'(gap_len_q) - LEN_W'(1);
              end
            end else begin
              cnt_d = cnt_q - LEN_W'(1);
            end
          end
        end
        S_GAP: begin
          if (tick_q) begin
            data_d = 1'b0;
            if (cnt_q == '0) begin
              state_d = S_BURST;
              idx_d   = idx_q + CNT_W'(1);
              cnt_d   = burst_len_q - LEN_W'(1);
            end else begin
              cnt_d = cnt_q - LEN_W'(1);
            end
          end
        end
        S_DONE: begin
          data_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_test_seq_ctrl.sv
// Directed bench for test_seq_ctrl.
// A PRBS7 LFSR in the bench drives prbs_bit_i. Expected bit streams are
// computed from a software PRBS7 model together with the run configuration.
module tb_test_seq_ctrl;
  localparam int LEN_W = 16;
  localparam int CNT_W = 8;
`ifdef TEST_SEQ_ERR_INJ_EN
  localparam bit INJ = 1'b1;
`else
  localparam bit INJ = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             test_clk = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] pre_len = '0;
  logic [LEN_W-1:0] burst_len = '0;
  logic [CNT_W-1:0] gap_len = '0;
  logic [CNT_W-1:0] burst_cnt = '0;
  logic [LEN_W-1:0] err_pos = '0;
  logic             prbs_bit;
  logic             prbs_en, prbs_init, test_data, busy, done;
  logic [CNT_W-1:0] burst_idx;

  test_seq_ctrl #(.LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .test_clk_i(test_clk), .start_i(start), .abort_i(abort),
    .preamble_len_i(pre_len), .burst_len_i(burst_len), .gap_len_i(gap_len),
    .burst_cnt_i(burst_cnt), .err_pos_i(err_pos), .prbs_bit_i(prbs_bit),
    .prbs_en_o(prbs_en), .prbs_init_o(prbs_init), .test_data_o(test_data),
    .busy_o(busy), .done_o(done), .burst_idx_o(burst_idx)
  );

  always #5 clk = ~clk;
  always #40 test_clk = ~test_clk;

  logic [6:0] lfsr = 7'h7F;
  always @(posedge clk)
    if (!rst_n || prbs_init) lfsr <= 7'h7F;
    else if (prbs_en)        lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  assign prbs_bit = lfsr[6];

  // The bench's own view of when a bit should be emitted.
  logic tc_q = 1'b0, tk = 1'b0;
  always @(posedge clk) begin
    tc_q <= test_clk;
    tk   <= test_clk & ~tc_q;
  end

  logic       rec_bit [0:4095];
  logic [7:0] rec_idx [0:4095];
  int rec_n = 0, cyc = 0, last_rec_cyc = 0, done_cyc = -1;
  int en_n = 0, done_n = 0, init_n = 0, busy_n = 0;
  logic       pend = 1'b0;
  logic [7:0] pend_idx = '0;

  always @(negedge clk) begin
    cyc++;
    if (pend && rec_n < 4096) begin
      rec_bit[rec_n] = test_data;
      rec_idx[rec_n] = pend_idx;
      rec_n++;
      last_rec_cyc = cyc;
    end
    pend     = tk && busy && !done && !abort;
    pend_idx = burst_idx;
    if (prbs_en)   en_n++;
    if (done)      begin done_n++; done_cyc = cyc; end
    if (prbs_init) init_n++;
    if (busy)      busy_n++;
  end

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic prbs_at(int k);
    logic [6:0] l = 7'h7F;
    for (int i = 0; i < k; i++) l = {l[5:0], l[6] ^ l[5]};
    return l[6];
  endfunction

  function automatic logic exp_bit(int k, int pre, int len, int gap, int epos);
    int per, b, p;
    if (k < pre) return (k % 2) == 0;
    k = k - pre;
    per = len + gap;
    b = k / per;
    p = k % per;
    if (p >= len) return 1'b0;
    return prbs_at(b * len + p) ^ (INJ && p == epos && epos < len);
  endfunction

  function automatic int exp_idx(int k, int pre, int len, int gap);
    if (k < pre) return 0;
    return ((k - pre) / (len + gap)) % 256;
  endfunction

  task automatic start_run(input int p, input int l, input int g, input int c, input int e);
    @(posedge clk); #1;
    pre_len = CNT_W'(p); burst_len = LEN_W'(l); gap_len = CNT_W'(g);
    burst_cnt = CNT_W'(c); err_pos = LEN_W'(e);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    int d0 = done_n;
    while (done_n == d0 && n < max) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    chk(tag, done_n != d0, 1'b1);
  endtask

  task automatic check_stream(input string tag, input int base, input int nbits,
                              input int p, input int l, input int g, input int e);
    chk({tag, "_nbits"}, rec_n - base, nbits);
    for (int k = 0; k < nbits; k++) begin
      chk($sformatf("%s_bit%0d", tag, k), rec_bit[base + k], exp_bit(k, p, l, g, e));
      chk($sformatf("%s_idx%0d", tag, k), rec_idx[base + k], exp_idx(k, p, l, g));
    end
  endtask

  initial begin
    int base, e0, d0, i0, b0, n, mism_b, mism_i, wrap;

    // Reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prbs_en", prbs_en, 1'b0);
    chk("rst_prbs_init", prbs_init, 1'b0);
    chk("rst_data", test_data, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_idx", burst_idx, 8'd0);
    rst_n = 1'b1;

    // Idle with the test clock running.
    e0 = en_n; b0 = busy_n;
    repeat (40) @(posedge clk);
    #1;
    chk("idle_en_pulses", en_n - e0, 0);
    chk("idle_busy_cycles", busy_n - b0, 0);
    chk("idle_data", test_data, 1'b0);

    // Run A: preamble 4, burst 8, gap 2, two bursts, err_pos 3.
    base = rec_n; e0 = en_n; d0 = done_n; i0 = init_n;
    start_run(4, 8, 2, 2, 3);
    chk("a_busy", busy, 1'b1);
    wait_done("a_done_wait", 1000);
    check_stream("a", base, 22, 4, 8, 2, 3);
    chk("a_en_pulses", en_n - e0, 16);
    chk("a_done_pulses", done_n - d0, 1);
    chk("a_init_pulses", init_n - i0, 1);
    chk("a_done_timing", done_cyc, last_rec_cyc);
    chk("a_busy_after", busy, 1'b0);
    chk("a_data_after", test_data, 1'b0);

    // Run B: no preamble, no gap, two bursts of 8 with err_pos 8 (out of range).
    repeat (10) @(posedge clk);
    base = rec_n; e0 = en_n;
    start_run(0, 8, 0, 2, 8);
    wait_done("b_done_wait", 1000);
    check_stream("b", base, 16, 0, 8, 0, 8);
    chk("b_en_pulses", en_n - e0, 16);

    // Run C: a start request while busy is ignored.
    repeat (10) @(posedge clk);
    base = rec_n; e0 = en_n; i0 = init_n;
    start_run(2, 4, 1, 1, 0);
    repeat (20) @(posedge clk);
    start_run(0, 8, 0, 3, 2);
    wait_done("c_done_wait", 1000);
    check_stream("c", base, 6, 2, 4, 1, 0);
    chk("c_en_pulses", en_n - e0, 4);
    chk("c_init_pulses", init_n - i0, 1);

    // start and abort together in IDLE.
    repeat (5) @(posedge clk);
    #1;
    i0 = init_n; b0 = busy_n;
    start = 1'b1; abort = 1'b1;
    #3;
    chk("sa_init_comb", prbs_init, 1'b0);
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("sa_busy_cycles", busy_n - b0, 0);
    chk("sa_init_pulses", init_n - i0, 0);

    // burst_len 0: done on the next cycle, no bits.
    base = rec_n; e0 = en_n;
    start_run(3, 0, 1, 1, 0);
    chk("z_done", done, 1'b1);
    @(posedge clk); #1;
    chk("z_busy_after", busy, 1'b0);
    chk("z_bits", rec_n - base, 0);
    chk("z_en_pulses", en_n - e0, 0);

    // Continuous: burst 4, gap 0, 300+ bursts, then abort mid-burst.
    repeat (5) @(posedge clk);
    base = rec_n;
    start_run(0, 4, 0, 0, 1);
    n = 0;
    while (!((rec_n - base) >= 1202 && ((rec_n - base) % 4) == 2) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("cont_reach_wait", n < 20000, 1'b1);
    mism_b = 0; mism_i = 0; wrap = 0;
    for (int k = 0; k < 1200; k++) begin
      if (rec_bit[base + k] !== exp_bit(k, 0, 4, 0, 1)) mism_b++;
      if (rec_idx[base + k] !== 8'(exp_idx(k, 0, 4, 0))) mism_i++;
      if (k > 0 && rec_idx[base + k - 1] === 8'd255 && rec_idx[base + k] === 8'd0) wrap = 1;
    end
    chk("cont_bit_mismatches", mism_b, 0);
    chk("cont_idx_mismatches", mism_i, 0);
    chk("cont_idx_wrap", wrap, 1);
    chk("cont_busy", busy, 1'b1);
    @(posedge clk); #1;
    d0 = done_n; e0 = en_n;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_data", test_data, 1'b0);
    chk("abort_idx", burst_idx, 8'd0);
    chk("abort_en_pulses", en_n - e0, 0);
    chk("abort_no_done", done_n - d0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_busy", busy, 1'b1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("final_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
